// File: rtl/pwd_entry_collector.sv
// Collects keypad bytes into a zero-padded candidate; ENTER accepted in cycle T gives cand_valid at T+2 for every length.
// Candidate is held stable until cand_ready; key_ready is low outside IDLE/COLLECT, and the buffer is wiped after every exit.
module pwd_entry_collector #(
    parameter int MAX_LEN = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         key_valid,
    input  logic [7:0]                   key_data,
    input  logic                         key_last,
    output logic                         key_ready,
    input  logic                         clear,
    output logic                         cand_valid,
    output logic [MAX_LEN*8-1:0]         cand_data,
    output logic [$clog2(MAX_LEN+1)-1:0] cand_len,
    output logic                         cand_ovf,
    input  logic                         cand_ready,
    output logic                         busy
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEAL,
        S_PRESENT,
        S_WIPE
    } state_t;

    state_t               state_q;
    logic [7:0]           buf_q [MAX_LEN];
    logic [CNT_W-1:0]     count_q;
    logic [TMR_W-1:0]     timer_q;
    logic [TMR_W-1:0]     timer_d;
    logic                 ovf_q;
    logic                 cand_valid_q;
    logic [MAX_LEN*8-1:0] cand_data_q;
    logic [CNT_W-1:0]     cand_len_q;
    logic                 cand_ovf_q;

    logic                 accepting;
    logic                 beat;
    logic                 data_beat;
    logic                 enter_beat;
    logic                 timeout_hit;
    logic [MAX_LEN*8-1:0] buf_flat;

    assign accepting  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    // clear takes priority over a beat offered in the same cycle
    assign beat       = key_valid && accepting && !clear;
    assign data_beat  = beat && !key_last;
    assign enter_beat = beat && key_last;
    assign timeout_hit = (timer_q >= TMR_W'(TIMEOUT - 1));

    always_comb begin
        timer_d = timer_q;
        if (timer_q != TMR_W'(TIMEOUT)) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        buf_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            buf_flat[i*8 +: 8] = buf_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
            count_q      <= '0;
            timer_q      <= '0;
            ovf_q        <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_data_q  <= '0;
            cand_len_q   <= '0;
            cand_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (clear) begin
                        state_q <= S_WIPE;
                    end else if (enter_beat) begin
                        state_q <= S_SEAL;
                    end else if (data_beat) begin
                        buf_q[0] <= key_data;
                        count_q  <= CNT_W'(1);
                        state_q  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (clear) begin
                        state_q <= S_WIPE;
                    end else if (enter_beat) begin
                        timer_q <= '0;
                        state_q <= S_SEAL;
                    end else if (data_beat) begin
                        timer_q <= '0;
                        if (count_q == CNT_W'(MAX_LEN)) begin
                            ovf_q <= 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (count_q == CNT_W'(i)) begin
                                    buf_q[i] <= key_data;
                                end
                            end
                            count_q <= count_q + CNT_W'(1);
                        end
                    end else if (timeout_hit) begin
                        state_q <= S_WIPE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                S_SEAL: begin
                    // same single cycle whatever the entry; overflow masks content and length
                    cand_valid_q <= 1'b1;
                    cand_ovf_q   <= ovf_q;
                    cand_len_q   <= ovf_q ? '0 : count_q;
                    cand_data_q  <= ovf_q ? '0 : buf_flat;
                    state_q      <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (cand_ready) begin
                        cand_valid_q <= 1'b0;
                        cand_data_q  <= '0;
                        cand_len_q   <= '0;
                        cand_ovf_q   <= 1'b0;
                        state_q      <= S_WIPE;
                    end
                end
                S_WIPE: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        buf_q[i] <= '0;
                    end
                    count_q      <= '0;
                    timer_q      <= '0;
                    ovf_q        <= 1'b0;
                    cand_valid_q <= 1'b0;
                    cand_data_q  <= '0;
                    cand_len_q   <= '0;
                    cand_ovf_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_WIPE;
                end
            endcase
        end
    end

    // gated by reset_n so upstream sees no ready while reset is asserted
    assign key_ready  = reset_n && accepting;
    assign cand_valid = cand_valid_q;
    assign cand_data  = cand_data_q;
    assign cand_len   = cand_len_q;
    assign cand_ovf   = cand_ovf_q;
    assign busy       = (state_q != S_IDLE);

endmodule
